// File: rtl/approx_eval_pkg.sv
// Shared types and width helpers for exhaustive approximate-circuit evaluators.
package approx_eval_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  function automatic int op_w(input int n_in);
    return n_in / 2;
  endfunction

  function automatic int sum_w(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/approx_mul_error_monitor_exact_mul.sv
// Golden unsigned multiplier: A = vec low half, B = vec high half, product truncated to N_OUT bits.
module exact_mul
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic [N_IN-1:0]  vec,
  output logic [N_OUT-1:0] prod
);

  localparam int OP_W = op_w(N_IN);
  // Wide enough for both the full product and the requested output width.
  localparam int FW   = (N_OUT > N_IN) ? N_OUT : N_IN;

  logic [FW-1:0] a_ext;
  logic [FW-1:0] b_ext;
  logic [FW-1:0] full;

  assign a_ext = {{(FW-OP_W){1'b0}}, vec[OP_W-1:0]};
  assign b_ext = {{(FW-OP_W){1'b0}}, vec[N_IN-1:OP_W]};
  assign full  = a_ext * b_ext;
  assign prod  = full[N_OUT-1:0];

endmodule

// File: rtl/approx_mul_error_monitor.sv
// Sweeps every input vector through an approximate multiplier and accumulates
// max / sum / count of absolute errors against the exact product.
module approx_mul_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int ET    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       stim,
  input  logic [N_OUT-1:0]      approx_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN-1:0]       worst_vec,
  output logic [N_IN+N_OUT-1:0] err_sum,
  output logic [N_IN:0]         err_count
);

  localparam int SUM_W = sum_w(N_IN, N_OUT);
  localparam int CNT_W = cnt_w(N_IN);

  state_t state, state_nxt;
  logic   enter_sweep;
  logic   last_vec;

  logic [N_OUT-1:0] exact_c;
  logic [N_OUT-1:0] exact_p1;
  logic [N_OUT-1:0] approx_p1;
  logic [N_IN-1:0]  vec_p1;
  logic             vld_p1;

  logic [N_OUT-1:0] err_c;
  logic [N_OUT-1:0] max_nxt;

  exact_mul #(.N_IN(N_IN), .N_OUT(N_OUT)) u_exact (
    .vec  (stim),
    .prod (exact_c)
  );

  assign last_vec = (stim == '1);
  assign busy     = (state == SWEEP) || (state == DRAIN);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt   = state;
    enter_sweep = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SWEEP;
          enter_sweep = 1'b1;
        end
      end
      SWEEP: begin
        if (last_vec) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt   = SWEEP;
          enter_sweep = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stim   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == SWEEP);
      // stim stops at all-ones so DRAIN/DONE keep presenting the last vector.
      if (enter_sweep)
        stim <= '0;
      else if ((state == SWEEP) && !last_vec)
        stim <= stim + N_IN'(1);
    end
  end

  // ---- stage 1: capture exact, approx and vector ----
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      exact_p1  <= exact_c;
      approx_p1 <= approx_out;
      vec_p1    <= stim;
    end
  end

  // ---- stage 2: absolute error and accumulation ----
  assign err_c   = (exact_p1 >= approx_p1) ? (exact_p1 - approx_p1) : (approx_p1 - exact_p1);
  assign max_nxt = (vld_p1 && (err_c > max_err)) ? err_c : max_err;

  always_ff @(posedge clk) begin
    if (rst || enter_sweep) begin
      max_err   <= '0;
      worst_vec <= '0;
      err_sum   <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      if (vld_p1) begin
        err_sum   <= err_sum + SUM_W'(err_c);
        err_count <= err_count + CNT_W'(err_c != '0);
        // Strict compare: ties keep the earliest vector.
        if (err_c > max_err) begin
          max_err   <= err_c;
          worst_vec <= vec_p1;
        end
      end
      // The final vector lands on the DRAIN edge, so judge against max_nxt.
      if (state == DRAIN)
        pass <= (int'(max_nxt) <= ET);
    end
  end

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// Directed bench: behavioural approximate multipliers swept through the monitor.
module tb_approx_mul_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] stim;
  logic [3:0] approx_out;
  logic       busy, done, pass;
  logic [3:0] max_err;
  logic [3:0] worst_vec;
  logic [7:0] err_sum;
  logic [4:0] err_count;

  int mode;
  int tests    = 0;
  int failures = 0;
  int cyc;

  logic [3:0] ex_m;

  always #5 clk = ~clk;

  approx_mul_error_monitor #(.N_IN(4), .N_OUT(4), .ET(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stim       (stim),
    .approx_out (approx_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .max_err    (max_err),
    .worst_vec  (worst_vec),
    .err_sum    (err_sum),
    .err_count  (err_count)
  );

  // Approximate circuit models: 0 exact, 1 stuck 0, 2 stuck F, 3 bit-2 flip when A==3.
  assign ex_m = {2'b00, stim[1:0]} * {2'b00, stim[3:2]};

  always_comb begin
    approx_out = ex_m;
    case (mode)
      1: approx_out = 4'h0;
      2: approx_out = 4'hF;
      3: approx_out = (stim[1:0] == 2'd3) ? (ex_m ^ 4'b0100) : ex_m;
      default: approx_out = ex_m;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int me, input int wv, input int sm,
                         input int cn, input int ps);
    chk({tag, ".max_err"},   32'(max_err),   32'(me));
    chk({tag, ".worst_vec"}, 32'(worst_vec), 32'(wv));
    chk({tag, ".err_sum"},   32'(err_sum),   32'(sm));
    chk({tag, ".err_count"}, 32'(err_count), 32'(cn));
    chk({tag, ".pass"},      32'(pass),      32'(ps));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stim"}, 32'(stim), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk_res(tag, 0, 0, 0, 0, 0);
  endtask

  // Counts edges from the start-accepting edge (edge 0 counts as 1) until done is seen.
  task automatic wait_done(input bit repulse, inout int c);
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
      start = (repulse && c == 5);
    end
    start = 1'b0;
  endtask

  task automatic sweep(input bit repulse, output int c);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1;
    wait_done(repulse, c);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Exact model
    mode = 0;
    sweep(1'b0, cyc);
    chk("exact.latency", 32'(cyc), 32'd18);
    chk("exact.stim_hold", 32'(stim), 32'hF);
    chk_res("exact", 0, 0, 0, 0, 1);

    // Stuck at 0
    mode = 1;
    sweep(1'b0, cyc);
    chk("stuck0.latency", 32'(cyc), 32'd18);
    chk_res("stuck0", 9, 15, 36, 9, 0);

    // Stuck at F
    mode = 2;
    sweep(1'b0, cyc);
    chk_res("stuckF", 15, 0, 204, 16, 0);

    // Flip bit 2 when A == 3
    mode = 3;
    sweep(1'b0, cyc);
    chk_res("xorA3", 4, 3, 16, 4, 1);

    // Reset mid-sweep discards partial results
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_zero("midrst");

    // Fresh sweep with start re-pulsed while busy
    sweep(1'b1, cyc);
    chk("repulse.latency", 32'(cyc), 32'd18);
    chk_res("repulse", 9, 15, 36, 9, 0);

    // Back-to-back restart from DONE
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.done", 32'(done), 32'd0);
    chk("b2b.stim", 32'(stim), 32'd0);
    chk_res("b2b.clear", 0, 0, 0, 0, 0);
    cyc = 1;
    wait_done(1'b0, cyc);
    chk("b2b.latency", 32'(cyc), 32'd18);
    chk_res("b2b", 9, 15, 36, 9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
